// File: rtl/md_unit_ctrl.sv
// md_unit_ctrl: multiply/divide sequencer with HI/LO registers.
// Accepts one MD op from the E stage and computes its result at issue.
// The result is held for a fixed latency and committed to HI/LO when the
// busy window closes. mthi/mtlo write directly at their issue edge.
// md_stall holds D-stage HI/LO-class instructions until the unit is free.
module md_unit_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_D,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_stall
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      pend_hi, pend_lo;

  logic             issue_long;   // multi-cycle op accepted this edge
  logic             last_cycle;   // final busy cycle, commit at next edge

  logic [63:0]        prod_s, prod_u;
  logic signed [31:0] quo_s, rem_s;
  logic [31:0]        quo_u, rem_u;
  logic               div_zero, div_ovf;
  logic [31:0]        res_hi, res_lo;

  // Sign-extend both operands to 64 bits; the low 64 bits of the wide
  // product are then the correct signed product.
  assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // SV signed division truncates toward zero, and the remainder takes the
  // sign of the dividend, which matches the MIPS definition.
  assign quo_s = $signed(rs_val) / $signed(rt_val);
  assign rem_s = $signed(rs_val) % $signed(rt_val);
  assign quo_u = rs_val / rt_val;
  assign rem_u = rs_val % rt_val;

  assign div_zero = (rt_val == 32'd0);
  assign div_ovf  = (rs_val == 32'h8000_0000) && (rt_val == 32'hFFFF_FFFF);

  // Select the result to be committed for the op being issued.
  // Divide by zero keeps the current HI/LO.
  always_comb begin
    // NOTE: defaults first on every path so no latch is inferred.
    res_hi = hi;
    res_lo = lo;
    case (md_op)
      OP_MULT:  {res_hi, res_lo} = prod_s;
      OP_MULTU: {res_hi, res_lo} = prod_u;
      OP_DIV: begin
        if (div_ovf) begin
          res_hi = 32'd0;
          res_lo = 32'h8000_0000;
        end else if (!div_zero) begin
          res_hi = rem_s;
          res_lo = quo_s;
        end
      end
      OP_DIVU: begin
        if (!div_zero) begin
          res_hi = rem_u;
          res_lo = quo_u;
        end
      end
      default: ;
    endcase
  end

  assign issue_long = start && (state == S_IDLE) && !md_op[2];
  assign last_cycle = (state == S_BUSY) && (cnt <= CNT_ONE);

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    // NOTE: non-blocking for every registered signal so all flops update together.
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (issue_long) state_nx = S_BUSY;
      S_BUSY:  if (last_cycle) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Counter, pending result and HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else if (state == S_IDLE) begin
      if (start) begin
        case (md_op)
          OP_MULT, OP_MULTU: begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            cnt     <= MULT_LOAD;
          end
          OP_DIV, OP_DIVU: begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            cnt     <= DIV_LOAD;
          end
          OP_MTHI: hi <= rs_val;
          OP_MTLO: lo <= rs_val;
          default: ;
        endcase
      end
    end else begin
      if (last_cycle) begin
        hi  <= pend_hi;
        lo  <= pend_lo;
        cnt <= '0;
      end else begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  assign busy = (state == S_BUSY);

  // start covers the cycle where an op sits in E before busy registers.
  assign md_stall = md_use_D & (busy | start);

endmodule

// File: tb/tb_md_unit_ctrl.sv
// tb_md_unit_ctrl: scoreboard bench for md_unit_ctrl.
// Each issued op pushes its expected HI/LO and busy length; the entry is
// popped and compared when the unit finishes.
module tb_md_unit_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        md_use_D;
  logic        busy;
  logic [31:0] hi, lo;
  logic        md_stall;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] m_hi, m_lo;
  int          n_checks = 0;
  int          n_pass   = 0;

  md_unit_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .md_use_D (md_use_D),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo),
    .md_stall (md_stall)
  );

  always #5 clk = ~clk;

  // The hazard unit never lets a new op reach E while the unit is busy.
  always @(negedge clk) begin
    if (!reset) assert (!(start && busy)) else $error("start while busy");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // Reference model of the MIPS HI/LO semantics.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output exp_t e);
    int                 sa, sb_;
    longint             p, q, r;
    longint unsigned    pu;
    e.hi = m_hi;
    e.lo = m_lo;
    e.cycles = 0;
    sa  = a;
    sb_ = b;
    case (op)
      3'd0: begin p = longint'(sa) * longint'(sb_); e.hi = p[63:32]; e.lo = p[31:0]; e.cycles = 5; end
      3'd1: begin pu = {32'd0, a} * {32'd0, b}; e.hi = pu[63:32]; e.lo = pu[31:0]; e.cycles = 5; end
      3'd2: begin
        e.cycles = 10;
        if (b != 0) begin
          q = longint'(sa) / longint'(sb_);
          r = longint'(sa) % longint'(sb_);
          e.lo = q[31:0];
          e.hi = r[31:0];
        end
      end
      3'd3: begin
        e.cycles = 10;
        if (b != 0) begin e.lo = a / b; e.hi = a % b; end
      end
      3'd4: e.hi = a;
      3'd5: e.lo = a;
      default: ;
    endcase
  endtask

  // Issue one op, follow it to completion and compare against the scoreboard.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic use_d);
    exp_t e;
    int   n;
    model(op, a, b, e);
    sb.push_back(e);
    m_hi = e.hi;
    m_lo = e.lo;

    @(posedge clk); #1;
    start = 1'b1; md_op = op; rs_val = a; rt_val = b; md_use_D = use_d;
    @(negedge clk);
    check({tag, "_stall_issue"}, {31'd0, md_stall}, {31'd0, use_d});
    @(posedge clk); #1;
    start = 1'b0;

    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      n++;
      if (use_d) check({tag, "_stall_busy"}, {31'd0, md_stall}, 32'd1);
    end
    md_use_D = 1'b0;
    e = sb.pop_front();
    check({tag, "_busy_len"}, n, e.cycles);
    if (use_d) check({tag, "_stall_drop"}, {31'd0, md_stall}, 32'd0);
    check({tag, "_hi"}, hi, e.hi);
    check({tag, "_lo"}, lo, e.lo);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_val = 32'd0; rt_val = 32'd0; md_use_D = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;

    // During reset the stall is purely md_use_D & start.
    #12;
    md_use_D = 1'b1; start = 1'b1; #1;
    check("rst_stall", {31'd0, md_stall}, 32'd1);
    md_use_D = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    // Reset in the middle of a mult: op aborted, no late commit.
    do_op("mthi_pre", 3'd4, 32'h0000_0055, 32'd0, 1'b0);
    @(posedge clk); #1;
    start = 1'b1; md_op = 3'd0; rs_val = 32'd3; rt_val = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1; #1;
    m_hi = 32'd0; m_lo = 32'd0;
    check("mid_busy", {31'd0, busy}, 32'd0);
    check("mid_hi", hi, 32'd0);
    check("mid_lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (8) @(negedge clk);
    check("mid_late_busy", {31'd0, busy}, 32'd0);
    check("mid_late_hi", hi, 32'd0);
    check("mid_late_lo", lo, 32'd0);

    // Arithmetic and stall cases.
    do_op("mult_s", 3'd0, 32'hFFFF_FFFE, 32'd3, 1'b1);
    do_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    do_op("div_s", 3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
    do_op("mthi", 3'd4, 32'h0000_0011, 32'd0, 1'b0);
    do_op("mtlo", 3'd5, 32'h0000_0022, 32'd0, 1'b0);
    do_op("divu_z", 3'd3, 32'h1234_5678, 32'd0, 1'b0);
    do_op("div_z", 3'd2, 32'h8765_4321, 32'd0, 1'b0);
    do_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    do_op("mthi_ab", 3'd4, 32'hABCD_1234, 32'd0, 1'b0);
    do_op("rsvd6", 3'd6, 32'hDEAD_BEEF, 32'd1, 1'b0);
    do_op("div_neg", 3'd2, 32'd100, 32'hFFFF_FFF9, 1'b0);
    do_op("divu", 3'd3, 32'hFFFF_FFF0, 32'd7, 1'b0);

    // Random operands across the four arithmetic ops.
    for (int k = 0; k < 8; k++) begin
      do_op("rand", 3'($urandom_range(0, 3)), $urandom, $urandom, 1'($urandom_range(0, 1)));
    end

    check("sb_empty", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
